fetch_predictor: RTL
====================

FETCH_PREDICTOR -- requirements
Module: fetch_predictor

Interface
REQ-001 Parameter XLEN, default 32, address/data width in bits.
REQ-002 Parameter BHT_ENTRIES, default 16, number of predictor entries; power of two, minimum 2.
REQ-003 Parameter RESET_PC, default 0, PC value loaded by reset.
REQ-004 Port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_i  input  1  synchronous, active-high reset.
REQ-006 Port start_i  input  1  run enable; while low, PC holds RESET_PC.
REQ-007 Port stall_i  input  1  hazard stall; holds PC (replaces PCWrite low).
REQ-008 Port pc_o  output  XLEN  current fetch PC, driven from a register.
REQ-009 Port pred_taken_o  output  1  combinational prediction for pc_o; pipeline carries it to ID.
REQ-010 Port resolve_valid_i  input  1  branch resolved in ID this cycle.
REQ-011 Port resolve_pc_i  input  XLEN  PC of resolved branch.
REQ-012 Port resolve_taken_i  input  1  actual outcome (Equal & Branch).
REQ-013 Port resolve_target_i  input  XLEN  actual taken target (pc + (imm<<1)).
REQ-014 Port resolve_pred_i  input  1  prediction made when the branch was fetched.
REQ-015 Port flush_o  output  1  combinational; squash the IF/ID instruction.

Function
REQ-016 IDX = log2(BHT_ENTRIES); index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
REQ-017 Each entry: 2-bit saturating counter, valid bit, tag, XLEN-bit target.
REQ-018 pred_taken_o = counter[1] & valid & (tag == pc_o tag) for the entry indexed by pc_o.
REQ-019 mispredict = resolve_valid_i & (resolve_taken_i != resolve_pred_i); flush_o = mispredict, same cycle.
REQ-020 Next-PC priority: rst_i, then !start_i (RESET_PC), then mispredict (resolve_taken_i ? resolve_target_i : resolve_pc_i+4), then stall_i (hold), then pred_taken_o (stored target), else pc_o+4.
REQ-021 Mispredict overrides stall_i in the same cycle.
REQ-022 PC arithmetic is modulo 2^XLEN; pc_o+4 wraps from all-ones-minus-3 to 0.
REQ-023 On resolve_valid_i: counter +1 if taken (saturates at 3), -1 if not taken (saturates at 0); applied at next edge.
REQ-024 On resolve_valid_i & resolve_taken_i: entry valid <= 1, tag and target written from resolve_pc_i/resolve_target_i.
REQ-025 Not-taken resolution never clears valid and never changes tag or target.
REQ-026 Tag mismatch on a taken resolution replaces the entry; its counter is set to 2 (weakly taken).
REQ-027 Lookup and update of the same index in one cycle: lookup uses pre-update state.
REQ-028 Table updates proceed regardless of stall_i and start_i; they are blocked only by rst_i.
REQ-029 Prediction latency 0 cycles (combinational on pc_o); redirect latency 1 cycle (pc_o changes at next edge).

Reset
REQ-030 On rst_i at a clock edge: pc_o = RESET_PC; all counters = 1 (weakly not taken); all valid = 0.
REQ-031 While rst_i is high: pred_taken_o = 0, and flush_o is forced to 0.
REQ-032 Reset asserted mid-redirect discards the redirect; reset wins every other input.

Configuration
REQ-033 Macro FETCH_PREDICTOR_STATS_EN defined: add outputs branch_cnt_o and mispred_cnt_o, each 32 bits, registered.
REQ-034 branch_cnt_o counts resolve_valid_i cycles; mispred_cnt_o counts mispredict cycles.
REQ-035 Both counters saturate at 32'hFFFFFFFF and reset to 0.
REQ-036 Macro undefined: neither port exists and no counter logic is synthesised.
REQ-037 With the macro undefined, all other behaviour is identical.

Verification
REQ-038 Scenario 1 (reset/start): rst_i=1 then start_i=0 for 3 cycles -> pc_o=0, pred_taken_o=0; start_i=1 -> pc_o 0,4,8.
REQ-039 Scenario 2 (train): branch at 0x10, target 0x40, resolved taken twice with resolve_pred_i=0 -> flush_o=1 both times, pc_o=0x40 the following cycle; next fetch of 0x10 -> pred_taken_o=1, next pc_o=0x40.
REQ-040 Scenario 3 (mispredict not-taken): trained entry, resolve_taken_i=0, resolve_pred_i=1 at 0x10 -> flush_o=1, next pc_o=0x14, counter 3->2.
REQ-041 Scenario 4 (alias): BHT_ENTRIES=16, 0x10 trained; fetch 0x50 -> pred_taken_o=0 on tag mismatch; taken resolve of 0x50 replaces the entry.
REQ-042 Scenario 5 (stall/redirect clash): stall_i=1 with mispredict to 0x80 -> pc_o=0x80 next cycle; stall_i=1 alone -> pc_o held.
REQ-043 Scenario 6 (stats, macro on): 5 resolves, 2 mispredicts -> branch_cnt_o=5, mispred_cnt_o=2; rst_i -> both 0.

Source files
------------

// File: rtl/fetch_predictor.sv
// rtl/fetch_predictor.sv - fetch PC register with a tagged 2-bit branch history/target table
//
// Purpose: generates the instruction fetch PC and a same-cycle taken prediction
// for it from a direct-mapped table of 2-bit saturating counters with tags and
// stored targets. Branches resolved in ID train the table and, on a wrong
// prediction, redirect the PC one cycle later and squash the IF/ID instruction.
//
// Optional feature macro: FETCH_PREDICTOR_STATS_EN
//   When defined, adds saturating 32-bit resolve/mispredict counters.
//
// Ports:
//   clk_i            in   clock, all state on rising edge
//   rst_i            in   synchronous active-high reset
//   start_i          in   run enable; low holds PC at RESET_PC
//   stall_i          in   hazard stall; holds PC
//   pc_o             out  current fetch PC (registered)
//   pred_taken_o     out  combinational prediction for pc_o
//   resolve_valid_i  in   a branch resolved in ID this cycle
//   resolve_pc_i     in   PC of the resolved branch
//   resolve_taken_i  in   actual outcome
//   resolve_target_i in   actual taken target
//   resolve_pred_i   in   prediction made when the branch was fetched
//   flush_o          out  combinational squash of the IF/ID instruction
//   branch_cnt_o     out  (stats only) resolved-branch count
//   mispred_cnt_o    out  (stats only) mispredict count

module fetch_predictor #(
    parameter int              XLEN        = 32,
    parameter int              BHT_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    input  logic            resolve_valid_i,
    input  logic [XLEN-1:0] resolve_pc_i,
    input  logic            resolve_taken_i,
    input  logic [XLEN-1:0] resolve_target_i,
    input  logic            resolve_pred_i,
    output logic            flush_o
`ifdef FETCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispred_cnt_o
`endif
);

    localparam int IDX   = $clog2(BHT_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [XLEN-1:0]  r_pc;
    logic [1:0]       r_ctr    [BHT_ENTRIES];
    logic [BHT_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag    [BHT_ENTRIES];
    logic [XLEN-1:0]  r_target [BHT_ENTRIES];

    logic [IDX-1:0]   w_fidx;
    logic [TAG_W-1:0] w_ftag;
    logic             w_pred;
    logic             w_mispredict;
    logic [XLEN-1:0]  w_next_pc;
    logic [IDX-1:0]   w_ridx;
    logic [TAG_W-1:0] w_rtag;
    logic             w_rhit;
    logic [1:0]       w_ctr_next;

    // Fetch-side lookup; reads the table before any same-cycle update lands.
    assign w_fidx = r_pc[IDX+1:2];
    assign w_ftag = r_pc[XLEN-1:IDX+2];
    assign w_pred = ~rst_i & r_valid[w_fidx] & r_ctr[w_fidx][1] & (r_tag[w_fidx] == w_ftag);

    assign w_mispredict = resolve_valid_i & (resolve_taken_i != resolve_pred_i);

    assign pc_o         = r_pc;
    assign pred_taken_o = w_pred;
    assign flush_o      = w_mispredict & ~rst_i;

    // Reset is handled in the register itself; this is the non-reset priority chain.
    always_comb begin
        w_next_pc = r_pc + XLEN'(4);
        if (!start_i) begin
            w_next_pc = RESET_PC;
        end else if (w_mispredict) begin
            w_next_pc = resolve_taken_i ? resolve_target_i : (resolve_pc_i + XLEN'(4));
        end else if (stall_i) begin
            w_next_pc = r_pc;
        end else if (w_pred) begin
            w_next_pc = r_target[w_fidx];
        end
    end

    // Resolve-side update. An invalid entry counts as a miss, so a taken
    // resolution into it allocates with a weakly-taken counter.
    assign w_ridx = resolve_pc_i[IDX+1:2];
    assign w_rtag = resolve_pc_i[XLEN-1:IDX+2];
    assign w_rhit = r_valid[w_ridx] & (r_tag[w_ridx] == w_rtag);

    always_comb begin
        w_ctr_next = r_ctr[w_ridx];
        if (resolve_taken_i) begin
            if (!w_rhit) begin
                w_ctr_next = 2'd2;
            end else if (r_ctr[w_ridx] != 2'd3) begin
                w_ctr_next = r_ctr[w_ridx] + 2'd1;
            end
        end else if (r_ctr[w_ridx] != 2'd0) begin
            w_ctr_next = r_ctr[w_ridx] - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc    <= RESET_PC;
            r_valid <= '0;
            for (int k = 0; k < BHT_ENTRIES; k++) begin
                r_ctr[k]    <= 2'd1;
                r_tag[k]    <= '0;
                r_target[k] <= '0;
            end
        end else begin
            r_pc <= w_next_pc;
            // Training ignores start_i and stall_i on purpose.
            if (resolve_valid_i) begin
                r_ctr[w_ridx] <= w_ctr_next;
                if (resolve_taken_i) begin
                    r_valid[w_ridx]  <= 1'b1;
                    r_tag[w_ridx]    <= w_rtag;
                    r_target[w_ridx] <= resolve_target_i;
                end
            end
        end
    end

`ifdef FETCH_PREDICTOR_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (resolve_valid_i && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;
`endif

endmodule
